// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - MEM-stage data-memory access sequencer
// Checks alignment/range, drives a req/ready bus with timeout and stalls the pipeline for the transfer.
module dm_access_ctrl #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000,
  parameter int          TIMEOUT    = 16,
  parameter int          CNT_W      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             req, fault, misalign, go;
  logic [3:0]       be_nxt;
  logic [31:0]      wdata_nxt;

  // Size 3 is decoded as a word access.
  always_comb begin
    misalign = 1'b0;
    be_nxt   = 4'b1111;
    wdata_nxt = wdata;
    case (size)
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata[7:0]}};
      end
      2'b01: begin
        misalign  = addr[0];
        be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{wdata[15:0]}};
      end
      default: misalign = (addr[1:0] != 2'b00);
    endcase
  end

  // Gating with reset keeps every output low while reset is held.
  always_comb begin
    req       = (mem_rd | mem_wr) & ~flush & (state == IDLE) & reset;
    fault     = misalign | (addr >= ADDR_LIMIT);
    go        = req & ~fault;
    state_nxt = state;
    stall     = 1'b0;
    rvalid    = 1'b0;
    bus_err   = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    exc_adel  = 1'b0;
    exc_ades  = 1'b0;
    case (state)
      IDLE: begin
        exc_adel = req & fault & ~mem_wr;
        exc_ades = req & fault & mem_wr;
        stall    = go;
        if (go) state_nxt = BUSY;
      end
      BUSY: begin
        bus_req = 1'b1;
        bus_we  = we_q;
        stall   = 1'b1;
        if (bus_ready)             state_nxt = DONE;
        else if (cnt == CNT_LAST)  state_nxt = ERR;
      end
      DONE: begin
        rvalid    = ~we_q;
        state_nxt = IDLE;
      end
      default: begin
        bus_err   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && go) begin
        we_q      <= mem_wr;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= be_nxt;
        bus_wdata <= wdata_nxt;
        cnt       <= '0;
      end else if (state == BUSY) begin
        if (bus_ready) begin
          if (!we_q) rdata <= bus_rdata;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
MEM-stage data-memory access sequencer between the pipeline and the data bus (DM plus memory-mapped devices). It checks load/store alignment and range, raising AdEL/AdES to the exception unit, and generates lane enables and replicated write data. It runs a req/ready bus handshake with timeout, stalls the pipeline for the transfer, and returns the raw read word to the load-extension stage.

Parameters:
ADDR_LIMIT, 32'h0000_3000, first illegal byte address; any access at or above it is a range fault.
TIMEOUT, 16, max BUSY cycles waiting for bus_ready before abort (>=2).
CNT_W, 5, width of timeout counter (2^CNT_W > TIMEOUT).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (asserted at 0).
mem_rd  in  1  load request this cycle.
mem_wr  in  1  store request this cycle.
size  in  2  0 byte, 1 half, 2 word; 3 reserved (treated as word).
addr  in  32  byte address.
wdata  in  32  store data, right-aligned.
flush  in  1  kill current MEM instruction (exception/interrupt).
stall  out  1  hold pipeline at MEM.
rvalid  out  1  one-cycle pulse: rdata valid (loads only).
rdata  out  32  raw bus word, held until the next capture.
exc_adel  out  1  load address error.
exc_ades  out  1  store address error.
bus_err  out  1  one-cycle timeout pulse.
bus_req  out  1  bus request.
bus_we  out  1  write strobe.
bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
bus_be  out  4  byte lane enables.
bus_wdata  out  32  lane-replicated store data.
bus_ready  in  1  device accepts/completes transfer this cycle.
bus_rdata  in  32  read word, valid with bus_ready.

Behaviour:
- States: IDLE, BUSY, DONE, ERR. Reset forces IDLE immediately (async). All outputs are 0, counter 0, rdata 0.
- A request is valid when (mem_rd|mem_wr) & ~flush in IDLE. If both are set, it is a store (mem_wr wins).
- Fault check in IDLE, combinational: word needs addr[1:0]==0, half needs addr[0]==0, all need addr<ADDR_LIMIT.
- On fault: exc_adel (load) or exc_ades (store) is high the same cycle. No bus activity, stall=0, state stays IDLE.
- On a valid, legal request: stall=1 combinationally this cycle. On the clock edge, latch we, bus_addr, bus_be, bus_wdata; move to BUSY; clear the counter.
- Lane enables: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111. Loads drive the same enables.
- bus_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- BUSY: bus_req=1, bus_we=latched, stall=1. The counter increments each cycle without bus_ready.
- BUSY with bus_ready: if load, rdata<=bus_rdata. Go to DONE. Transfer latency is 1 cycle + device wait.
- BUSY with counter==TIMEOUT-1 and no bus_ready: go to ERR. bus_ready in that same cycle wins (DONE).
- DONE: bus_req=0, stall=0, rvalid=1 if the latched op was a load. The pipeline advances on this edge, then the state returns to IDLE. The request inputs seen in DONE are ignored (no re-issue).
- ERR: bus_err=1, stall=0, rvalid=0, then IDLE. rdata is unchanged.
- flush is sampled only in IDLE. Once BUSY, the transfer completes because a store side effect cannot be cancelled. flush during BUSY/DONE is ignored, and the exception unit takes the instruction after DONE.
- bus_addr/bus_be/bus_wdata hold their latched values outside BUSY. They are meaningful only when bus_req=1.
- Back-to-back accesses: minimum 3 cycles per access (IDLE, BUSY, DONE) with a zero-wait device.
- Reset asserted mid-BUSY: bus_req drops immediately. No rvalid or bus_err pulse.

Test Plan:
- lw addr=0x0000_0104, bus_ready in 1st BUSY cycle with rdata 0xDEADBEEF -> stall high 2 cycles, bus_be=1111, bus_addr=0x104, rvalid pulse with rdata=0xDEADBEEF.
- sb addr=0x0000_0203, wdata=0x0000_00A5 -> bus_we=1, bus_be=1000, bus_wdata=0xA5A5A5A5, no rvalid.
- lh addr=0x0000_0101 -> exc_adel=1 same cycle, bus_req never asserted, stall=0. sw addr=0x0000_3000 -> exc_ades=1.
- sh addr=0x0000_0012, bus_ready delayed 5 cycles -> stall high 6 cycles, bus_be=1100, wdata replicated in both halves, then release.
- lw with bus_ready never asserted, TIMEOUT=16 -> bus_err pulse exactly 16 cycles after entering BUSY, stall released, rdata unchanged. Repeat with bus_ready on the 16th cycle -> DONE, not ERR.
- flush with lw in IDLE -> no bus_req. flush asserted in BUSY -> transfer completes. reset=0 in BUSY -> bus_req and stall drop immediately, IDLE after release.
